multi_clkgen: RTL
=================

# multi_clkgen

Parametrised successor to the single-channel clock divider and millisecond counter. It provides `CHANNELS` independent, run-time-programmable square-wave/tick generators and an optional free-running millisecond counter. All of this runs from one system clock. It sits between the board oscillator and the peripheral blocks that need slow clocks, tick enables or a time base (timer, VGA blink, scan logic).

## Interface
- `CLK_FREQ`, default 100000000: input clock frequency in Hz.
- `CHANNELS`, default 4: number of divider channels, 1..16.
- `CNT_W`, default 32: width of each channel divisor and counter.
- `clkin`  input  1  system clock; all logic is on the rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `clken`  input  1  global enable; when 0, all state freezes.
- `ch_en`  input  CHANNELS  per-channel enable.
- `ch_div`  input  CHANNELS*CNT_W  per-channel half-period in `clkin` cycles; channel i uses bits [i*CNT_W +: CNT_W].
- `ch_clk`  output  CHANNELS  per-channel square wave, registered.
- `ch_tick`  output  CHANNELS  one-cycle pulse marking each rising edge of `ch_clk`, registered.
- `ms_run`  input  1  millisecond counter run enable.
- `ms_clr`  input  1  synchronous clear of the millisecond counter.
- `mscnt`  output  32  elapsed milliseconds, registered.
- `ms_tick`  output  1  one-cycle pulse on each `mscnt` increment.

## Operation
- Channel i has counter `cnt_i` (CNT_W bits) and divisor `d_i = ch_div[i]`. Its evaluation on each edge follows this priority:
  1. `rst`: `cnt_i`=0, `ch_clk[i]`=0, `ch_tick[i]`=0.
  2. `clken`=0: `cnt_i` and `ch_clk[i]` hold; `ch_tick[i]`=0.
  3. `ch_en[i]`=0 or `d_i`=0: `cnt_i`=0, `ch_clk[i]`=0, `ch_tick[i]`=0. Divisor 0 means idle.
  4. `cnt_i >= d_i-1`: `cnt_i`=0, `ch_clk[i]` toggles, `ch_tick[i]`=1 only if `ch_clk[i]` goes 0→1.
  5. Otherwise: `cnt_i`+1, `ch_tick[i]`=0.
- Output period is 2·`d_i` cycles at 50% duty. `d_i`=1 gives `clkin`/2.
- The `>=` compare makes divisor changes safe mid-count. If the new `d_i-1` is ≤ `cnt_i`, the channel toggles on the next enabled edge; otherwise it continues to the new limit. There is no wrap-through.
- Millisecond counter: prescaler `ms_pre` counts 0..`MS_LIM`, where `MS_LIM` = `CLK_FREQ`/1000 − 1 (99999 at 100 MHz). Its evaluation on each edge follows this priority:
  1. `rst` or `ms_clr`: `ms_pre`=0, `mscnt`=0, `ms_tick`=0.
  2. `clken`=0 or `ms_run`=0: hold; `ms_tick`=0.
  3. `ms_pre >= MS_LIM`: `ms_pre`=0, `mscnt`+1, `ms_tick`=1.
  4. Otherwise: `ms_pre`+1, `ms_tick`=0.
- `mscnt` wraps from 0xFFFFFFFF to 0 and still asserts `ms_tick`.
- If `ms_clr` is asserted on the same edge as a terminal count, the clear wins: `mscnt`=0 and no tick.

## Timing
- Reset values: `ch_clk`=0, `ch_tick`=0, `mscnt`=0, `ms_tick`=0.
- A channel enabled with divisor d from idle (`cnt_i`=0):
  - `ch_clk[i]` rises after the d-th enabled edge, with `ch_tick[i]` high in that same cycle.
  - `ch_clk[i]` falls after edge 2d.
  - The next rise is after edge 3d.
- `ch_tick` and `ch_clk` change on the same edge. A consumer that samples `ch_tick` sees exactly one high cycle per period.
- Deasserting `ch_en[i]` forces `ch_clk[i]` low on the next edge, which may give a truncated high phase. Re-enabling starts a full fresh count.
- `clken` low for N cycles stretches every period by exactly N cycles. No tick is generated or lost.
- First `ms_tick` after reset with `ms_run`=1: in the cycle after the (`MS_LIM`+1)-th edge; `mscnt`=1 from then on.
- Channels are fully independent. Simultaneous toggles on all channels are legal.

## Configuration
- `MULTI_CLKGEN_MS_EN`
  - Defined: the millisecond prescaler, `mscnt` and `ms_tick` are built as described.
  - Not defined: `mscnt` is tied to 0, `ms_tick` to 0, and `ms_run`/`ms_clr` are ignored. No prescaler registers are synthesised; channel behaviour is unchanged.

## Test plan
- Reset, CHANNELS=4, divisors {1,2,3,5}, all enabled, clken=1 → ch_clk periods 2/4/6/10 cycles, 50% duty; each ch_tick pulses once per period on the rising edge of its ch_clk.
- Channel 0 at d=10; at cnt=6 change div to 4 → toggle on the next edge; subsequent half-periods are 4 cycles.
- Hold clken=0 for 7 cycles mid-period, d=5 → that period measures 17 cycles; no extra or missing ticks.
- div=0 or ch_en=0 on channel 2 → ch_clk[2]=0 and ch_tick[2]=0 constantly; the other channels are unaffected.
- CLK_FREQ=10000 (MS_LIM=9), macro defined, ms_run=1 → ms_tick every 10 cycles; mscnt=3 after 30 cycles; ms_run=0 for 5 cycles delays the next tick by 5 cycles; ms_clr coincident with a tick → mscnt=0, no tick.
- Force mscnt to 0xFFFFFFFF, run → wraps to 0 with ms_tick=1; with the macro undefined, mscnt=0 and ms_tick=0 throughout.

Source files
------------

// File: rtl/multi_clkgen.sv
// rtl/multi_clkgen.sv - multi-channel programmable clock/tick divider with optional ms counter
// Optional feature macro: MULTI_CLKGEN_MS_EN (builds the millisecond prescaler and counter)
module multi_clkgen #(
   parameter int CLK_FREQ = 100000000,
   parameter int CHANNELS = 4,
   parameter int CNT_W    = 32
) (
   input  logic                      clkin,
   input  logic                      rst,
   input  logic                      clken,
   input  logic [CHANNELS-1:0]       ch_en,
   input  logic [CHANNELS*CNT_W-1:0] ch_div,
   output logic [CHANNELS-1:0]       ch_clk,
   output logic [CHANNELS-1:0]       ch_tick,
   input  logic                      ms_run,
   input  logic                      ms_clr,
   output logic [31:0]               mscnt,
   output logic                      ms_tick
);

   // Terminal value of the 1 ms prescaler (CLK_FREQ/1000 - 1)
   localparam logic [31:0] MS_LIM = 32'(CLK_FREQ / 1000 - 1);

   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
         logic [CNT_W-1:0] div_i;
         logic [CNT_W-1:0] cnt_r;
         logic             clk_r;
         logic             tick_r;

         assign div_i = ch_div[gi*CNT_W +: CNT_W];

         // Half-period counter; the >= compare lets a shrinking divisor take
         // effect on the next enabled edge instead of wrapping the counter
         always_ff @(posedge clkin) begin
            if (rst) begin
               cnt_r  <= '0;
               clk_r  <= 1'b0;
               tick_r <= 1'b0;
            end else if (!clken) begin
               tick_r <= 1'b0;
            end else if (!ch_en[gi] || div_i == '0) begin
               cnt_r  <= '0;
               clk_r  <= 1'b0;
               tick_r <= 1'b0;
            end else if (cnt_r >= div_i - 1'b1) begin
               cnt_r  <= '0;
               clk_r  <= ~clk_r;
               tick_r <= ~clk_r;
            end else begin
               cnt_r  <= cnt_r + 1'b1;
               tick_r <= 1'b0;
            end
         end

         assign ch_clk[gi]  = clk_r;
         assign ch_tick[gi] = tick_r;
      end
   endgenerate

`ifdef MULTI_CLKGEN_MS_EN
   logic [31:0] ms_pre;

   // Prescale clkin down to 1 ms and count elapsed milliseconds; clear wins over a tick
   always_ff @(posedge clkin) begin
      if (rst || ms_clr) begin
         ms_pre  <= '0;
         mscnt   <= '0;
         ms_tick <= 1'b0;
      end else if (!clken || !ms_run) begin
         ms_tick <= 1'b0;
      end else if (ms_pre >= MS_LIM) begin
         ms_pre  <= '0;
         mscnt   <= mscnt + 32'd1;
         ms_tick <= 1'b1;
      end else begin
         ms_pre  <= ms_pre + 32'd1;
         ms_tick <= 1'b0;
      end
   end
`else
   assign mscnt   = '0;
   assign ms_tick = 1'b0;

   logic unused_ms;
   assign unused_ms = ms_run ^ ms_clr ^ MS_LIM[0];
`endif

endmodule
